// File: rtl/sram_backup_pkg.sv
// Shared types and helpers for the SRAM backup controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sram_backup_pkg;

   typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} state_t;

   localparam int SECTOR_BYTES = 512;

   // Sector count of an image: whole sectors, truncated to size_w bits,
   // never less than one.
   function automatic logic [31:0] sect_count(input logic [31:0] img_size,
                                              input int          size_w);
      logic [31:0] n;
      n = (img_size >> $clog2(SECTOR_BYTES)) & ((32'd1 << size_w) - 32'd1);
      return (n == 32'd0) ? 32'd1 : n;
   endfunction

endpackage

// File: rtl/sram_backup_ctrl_if.sv
// Sector handshake (user_io side) and SDRAM port C strobes of the backup controller.
// Latency: n/a (wires only).
// Backpressure: request level held until sd_ack rises; mem_req is a pulse, no stall.
// master: controller (drives sd_lba/sd_rd/sd_wr/mem_*); slave: user_io + SDRAM side.
interface sram_backup_ctrl_if #(
   parameter int NUM_SLOTS = 2,
   parameter int SIZE_W    = 12
);
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic [31:0]              sd_lba;
   logic [NUM_SLOTS-1:0]     sd_rd;
   logic [NUM_SLOTS-1:0]     sd_wr;
   logic                     sd_ack;
   logic [8:0]               sd_buff_addr;
   logic                     sd_buff_wr;
   logic                     sd_buff_rd;
   logic                     mem_req;
   logic                     mem_we;
   logic [SLOT_W+SIZE_W+8:0] mem_addr;

   modport master (
      output sd_lba, sd_rd, sd_wr, mem_req, mem_we, mem_addr,
      input  sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_rd
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, mem_req, mem_we, mem_addr,
      output sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_rd
   );
endinterface

// File: rtl/sram_backup_ctrl_edge_det.sv
// Registered edge detector; each bit reports its rising edge, or its falling
// edge where FALL_MASK is set. Latency: edge flagged in the cycle the input changes.
// Backpressure: none. Ports: clk, rst_n (async low), din[W], edge_o[W].
module edge_det #(
   parameter int           W         = 1,
   parameter logic [W-1:0] FALL_MASK = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] edge_o
);
   logic [W-1:0] din_q, din_d;

   always_comb din_d = din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) din_q <= '0;
      else        din_q <= din_d;
   end

   always_comb begin
      edge_o = '0;
      for (int i = 0; i < W; i++)
         edge_o[i] = FALL_MASK[i] ? (din_q[i] & ~din[i]) : (din[i] & ~din_q[i]);
   end
endmodule

// File: rtl/sram_backup_ctrl.sv
// Moves battery-backed save RAM between SDRAM and up to NUM_SLOTS SD images, sector by sector.
// Latency: sd_buff_* strobe -> mem_req one cycle; transfer starts one cycle after its trigger edge.
// Backpressure: sd_rd/sd_wr held until sd_ack rises; a watchdog aborts a stalled sd_ack.
// Ports: clk, reset_n; mount/download/save/dirty controls; bus (sd_* + mem_*); ena/busy/dirty/error status.
module sram_backup_ctrl
   import sram_backup_pkg::*;
#(
   parameter int          NUM_SLOTS    = 2,
   parameter int          SIZE_W       = 12,
   parameter logic [31:0] AUTOSAVE_CYC = 32'd21_000_000,
   parameter logic [23:0] ACK_TIMEOUT  = 24'hFFFFFF,
   localparam int         SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_SLOTS-1:0] img_mounted,
   input  logic [31:0]          img_size,
   input  logic                 downloading,
   input  logic                 save_req,
   input  logic [SLOT_W-1:0]    slot_sel,
   input  logic                 dirty_set,
   sram_backup_ctrl_if.master   bus,
   output logic [NUM_SLOTS-1:0] ena,
   output logic                 busy,
   output logic                 dirty,
   output logic                 error
);
   logic [NUM_SLOTS-1:0] mnt_rise;
   logic                 save_rise, dl_rise;
   logic [1:0]           ack_edge;   // [1] fall, [0] rise

   edge_det #(.W(NUM_SLOTS)) u_mnt (.clk(clk), .rst_n(reset_n), .din(img_mounted), .edge_o(mnt_rise));
   edge_det #(.W(1)) u_save (.clk(clk), .rst_n(reset_n), .din(save_req),    .edge_o(save_rise));
   edge_det #(.W(1)) u_dl   (.clk(clk), .rst_n(reset_n), .din(downloading), .edge_o(dl_rise));
   edge_det #(.W(2), .FALL_MASK(2'b10)) u_ack (.clk(clk), .rst_n(reset_n),
                                               .din({bus.sd_ack, bus.sd_ack}), .edge_o(ack_edge));

   state_t                          state_q, state_d;
   logic [SLOT_W-1:0]               slot_q, slot_d;
   logic                            save_q, save_d;
   logic [SIZE_W-1:0]               sector_q, sector_d;
   logic [SIZE_W-1:0]               cur_nsect_q, cur_nsect_d;
   logic [NUM_SLOTS-1:0]            ena_q, ena_d;
   logic [NUM_SLOTS-1:0]            pend_q, pend_d;
   logic [NUM_SLOTS-1:0][SIZE_W-1:0] nsect_q, nsect_d;
   logic                            dirty_q, dirty_d;
   logic                            redirty_q, redirty_d;   // dirty_set seen since the save began
   logic                            error_q, error_d;
   logic [31:0]                     idle_q, idle_d;
   logic [23:0]                     wdog_q, wdog_d;
   logic                            mem_req_q, mem_req_d;
   logic                            mem_we_q, mem_we_d;
   logic [SLOT_W+SIZE_W+8:0]        mem_addr_q, mem_addr_d;

   logic              load_hit, save_go, ack_any;
   logic [SLOT_W-1:0] load_slot;

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      save_d      = save_q;
      sector_d    = sector_q;
      cur_nsect_d = cur_nsect_q;
      ena_d       = ena_q;
      pend_d      = pend_q;
      nsect_d     = nsect_q;
      dirty_d     = dirty_q;
      redirty_d   = redirty_q;
      error_d     = error_q;
      idle_d      = idle_q;
      wdog_d      = '0;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      ack_any     = ack_edge[0] | ack_edge[1];

      // Lowest pending slot wins: scan from the top so the last hit is the lowest.
      load_hit  = 1'b0;
      load_slot = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (pend_q[k]) begin
            load_hit  = 1'b1;
            load_slot = SLOT_W'(k);
         end
      end

      save_go = (save_rise || (dirty_q && (AUTOSAVE_CYC != 32'd0) && (idle_q == AUTOSAVE_CYC)))
                && ena_q[slot_sel];

      if (dirty_set)
         idle_d = '0;
      else if (dirty_q && (state_q == IDLE) && (idle_q != '1))
         idle_d = idle_q + 32'd1;

      case (state_q)
         IDLE: begin
            if (load_hit || save_go) begin
               state_d  = REQ;
               sector_d = '0;
               error_d  = 1'b0;
               if (load_hit) begin
                  slot_d            = load_slot;
                  save_d            = 1'b0;
                  pend_d[load_slot] = 1'b0;
                  cur_nsect_d       = nsect_q[load_slot];
               end else begin
                  slot_d      = slot_sel;
                  save_d      = 1'b1;
                  redirty_d   = 1'b0;
                  cur_nsect_d = nsect_q[slot_sel];
               end
            end
         end
         REQ, XFER: begin
            if ((state_q == REQ) && ack_edge[0]) begin
               state_d = XFER;
            end else if ((state_q == XFER) && ack_edge[1]) begin
               state_d = NEXT;
            end else if (!ack_any) begin
               if (wdog_q == ACK_TIMEOUT - 24'd1) begin
                  state_d = IDLE;
                  error_d = 1'b1;
               end else begin
                  wdog_d = wdog_q + 24'd1;
               end
            end
         end
         NEXT: begin
            if (sector_q == cur_nsect_q - 1'b1) begin
               state_d = IDLE;
               if (save_q) dirty_d = redirty_q;
            end else begin
               sector_d = sector_q + 1'b1;
               state_d  = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && (bus.sd_buff_wr || bus.sd_buff_rd)) begin
         mem_req_d  = 1'b1;
         mem_we_d   = bus.sd_buff_wr;
         mem_addr_d = {slot_q, sector_q, bus.sd_buff_addr};
      end

      if (dirty_set) begin
         dirty_d   = 1'b1;
         redirty_d = 1'b1;
      end

      // A remount of the active slot re-queues it; the running transfer keeps cur_nsect.
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (mnt_rise[k]) begin
            if (img_size != 32'd0) begin
               ena_d[k]   = 1'b1;
               pend_d[k]  = 1'b1;
               nsect_d[k] = SIZE_W'(sect_count(img_size, SIZE_W));
            end else begin
               ena_d[k]  = 1'b0;
               pend_d[k] = 1'b0;
            end
         end
      end

      if (dl_rise) begin
         ena_d   = '0;
         pend_d  = '0;
         dirty_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         save_q      <= 1'b0;
         sector_q    <= '0;
         cur_nsect_q <= '0;
         ena_q       <= '0;
         pend_q      <= '0;
         nsect_q     <= '0;
         dirty_q     <= 1'b0;
         redirty_q   <= 1'b0;
         error_q     <= 1'b0;
         idle_q      <= '0;
         wdog_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         save_q      <= save_d;
         sector_q    <= sector_d;
         cur_nsect_q <= cur_nsect_d;
         ena_q       <= ena_d;
         pend_q      <= pend_d;
         nsect_q     <= nsect_d;
         dirty_q     <= dirty_d;
         redirty_q   <= redirty_d;
         error_q     <= error_d;
         idle_q      <= idle_d;
         wdog_q      <= wdog_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign bus.sd_rd    = ((state_q == REQ) && !save_q) ? (NUM_SLOTS'(1) << slot_q) : '0;
   assign bus.sd_wr    = ((state_q == REQ) &&  save_q) ? (NUM_SLOTS'(1) << slot_q) : '0;
   assign bus.sd_lba   = {{(32 - SIZE_W){1'b0}}, sector_q};
   assign bus.mem_req  = mem_req_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign ena          = ena_q;
   assign busy         = (state_q != IDLE);
   assign dirty        = dirty_q;
   assign error        = error_q;
endmodule

// File: tb/tb_sram_backup_ctrl.sv
// Directed + randomized bench for sram_backup_ctrl: a user_io-style responder
// serves each sector request while a small model tracks ena/nsect/dirty.
module tb_sram_backup_ctrl;
   localparam int NS = 2;
   localparam int SW = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NS-1:0] img_mounted = '0;
   logic [31:0]   img_size = '0;
   logic          downloading = 1'b0;
   logic          save_req = 1'b0;
   logic [0:0]    slot_sel = '0;
   logic          dirty_set = 1'b0;
   logic [NS-1:0] ena;
   logic          busy, dirty, error;

   always #5 clk = ~clk;

   sram_backup_ctrl_if #(.NUM_SLOTS(NS), .SIZE_W(SW)) bus ();

   sram_backup_ctrl #(
      .NUM_SLOTS(NS), .SIZE_W(SW), .AUTOSAVE_CYC(32'd50), .ACK_TIMEOUT(24'd100)
   ) dut (
      .clk(clk), .reset_n(reset_n), .img_mounted(img_mounted), .img_size(img_size),
      .downloading(downloading), .save_req(save_req), .slot_sel(slot_sel),
      .dirty_set(dirty_set), .bus(bus), .ena(ena), .busy(busy), .dirty(dirty), .error(error)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // model state
   logic [NS-1:0] m_ena = '0;
   int            m_nsect [NS];

   // count distinct sector requests seen on sd_rd/sd_wr
   int   req_starts = 0;
   logic req_prev = 1'b0;
   always @(negedge clk) begin
      if (((|bus.sd_rd) || (|bus.sd_wr)) && !req_prev) req_starts++;
      req_prev = (|bus.sd_rd) || (|bus.sd_wr);
   end

   initial begin
      #500_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Whole 512-byte sectors, modulo 2^12, at least one.
   function automatic int exp_nsect(input logic [31:0] sz);
      int n;
      n = int'(sz / 32'd512) % 4096;
      return (n == 0) ? 1 : n;
   endfunction

   task automatic mount(input int slot, input logic [31:0] sz);
      img_mounted[slot] = 1'b1;
      img_size = sz;
      tick(1);
      img_mounted = '0;
      m_ena[slot] = (sz != 0);
      if (sz != 0) m_nsect[slot] = exp_nsect(sz);
   endtask

   task automatic pulse_dirty();
      dirty_set = 1'b1;
      tick(1);
      dirty_set = 1'b0;
   endtask

   // Responder for one whole transfer; checks request vector, LBA and memory strobes.
   task automatic serve(input int slot, input bit save, input int nsect, input bit poke);
      logic [NS-1:0] onehot;
      logic [21:0]   exp_addr;
      logic [8:0]    baddr;
      int            w;
      onehot = NS'(1) << slot;
      for (int s = 0; s < nsect; s++) begin
         w = 0;
         while (bus.sd_rd == '0 && bus.sd_wr == '0 && w < 200) begin
            tick(1);
            w++;
         end
         check("req_seen", (w < 200), 1'b1);
         if (w >= 200) return;
         check("req_rd", bus.sd_rd, save ? '0 : onehot);
         check("req_wr", bus.sd_wr, save ? onehot : '0);
         check("req_lba", bus.sd_lba, s);
         check("busy_xfer", busy, 1'b1);
         tick($urandom_range(0, 3));
         check("req_held", (bus.sd_rd | bus.sd_wr), onehot);
         bus.sd_ack = 1'b1;
         tick(1);
         check("req_drop", (bus.sd_rd | bus.sd_wr), '0);
         for (int b = 0; b < 3; b++) begin
            baddr = (b == 0) ? 9'd5 : 9'($urandom_range(0, 511));
            bus.sd_buff_addr = baddr;
            if (save) bus.sd_buff_rd = 1'b1;
            else      bus.sd_buff_wr = 1'b1;
            if (poke && b == 1) dirty_set = 1'b1;
            tick(1);
            bus.sd_buff_rd = 1'b0;
            bus.sd_buff_wr = 1'b0;
            dirty_set = 1'b0;
            exp_addr = {1'(slot), 12'(s), baddr};
            check("mem_req", bus.mem_req, 1'b1);
            check("mem_we", bus.mem_we, !save);
            check("mem_addr", bus.mem_addr, exp_addr);
            tick(1);
            check("mem_req_pulse", bus.mem_req, 1'b0);
         end
         bus.sd_ack = 1'b0;
         tick(1);
      end
      tick(1);   // controller passes through NEXT
      check("busy_done", busy, 1'b0);
   endtask

   int          rs, w, cnt, n, slot;
   logic [31:0] sz;

   initial begin
      bus.sd_ack = 1'b0;
      bus.sd_buff_addr = '0;
      bus.sd_buff_wr = 1'b0;
      bus.sd_buff_rd = 1'b0;
      m_nsect[0] = 0;
      m_nsect[1] = 0;

      // reset values
      tick(3);
      check("rst_sd_rd", bus.sd_rd, '0);
      check("rst_sd_wr", bus.sd_wr, '0);
      check("rst_sd_lba", bus.sd_lba, 0);
      check("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr}, '0);
      check("rst_status", {ena, busy, dirty, error}, '0);
      reset_n = 1'b1;
      tick(2);

      // A: 2048-byte image on slot 0 -> four sector loads
      rs = req_starts;
      mount(0, 32'd2048);
      serve(0, 1'b0, m_nsect[0], 1'b0);
      tick(4);
      check("A_sectors", req_starts - rs, 4);
      check("A_ena", ena, m_ena);

      // B: 100-byte image on slot 1 -> one sector
      rs = req_starts;
      mount(1, 32'd100);
      serve(1, 1'b0, m_nsect[1], 1'b0);
      tick(4);
      check("B_sectors", req_starts - rs, 1);
      check("B_ena", ena, m_ena);

      // C: autosave. The idle count reaches 50 fifty cycles after the pulse edge;
      // the transfer launches on that edge, so sd_wr is first seen on the 51st sample.
      slot_sel = 1'b0;
      pulse_dirty();
      cnt = 0;
      while (bus.sd_wr == '0 && cnt < 200) begin
         cnt++;
         tick(1);
      end
      check("C_autosave_delay", cnt, 51);
      check("C_dirty_before", dirty, 1'b1);
      serve(0, 1'b1, m_nsect[0], 1'b0);
      check("C_dirty_after", dirty, 1'b0);

      // D: manual save on slot 1 with a dirty_set during the save
      pulse_dirty();
      slot_sel = 1'b1;
      save_req = 1'b1;
      tick(1);
      save_req = 1'b0;
      serve(1, 1'b1, m_nsect[1], 1'b1);
      check("D_dirty_kept", dirty, 1'b1);
      serve(1, 1'b1, m_nsect[1], 1'b0);   // the resulting autosave
      check("D_dirty_clear", dirty, 1'b0);

      // E: save request on a disabled slot is ignored
      mount(1, 32'd0);
      tick(2);
      check("E_ena", ena, m_ena);
      rs = req_starts;
      pulse_dirty();
      save_req = 1'b1;
      tick(1);
      save_req = 1'b0;
      tick(80);
      check("E_no_xfer", req_starts - rs, 0);
      check("E_dirty_kept", dirty, 1'b1);
      downloading = 1'b1;
      tick(1);
      m_ena = '0;
      check("E_dl_ena", ena, m_ena);
      check("E_dl_dirty", dirty, 1'b0);
      downloading = 1'b0;
      tick(2);

      // F: ack never arrives -> watchdog
      pulse_dirty();
      sz = 32'($urandom_range(1, 4)) * 32'd512;
      mount(0, sz);
      w = 0;
      while (bus.sd_rd == '0 && w < 50) begin
         tick(1);
         w++;
      end
      cnt = 0;
      while (bus.sd_rd != '0 && cnt < 300) begin
         cnt++;
         tick(1);
      end
      check("F_timeout_len", cnt, 100);
      check("F_error", error, 1'b1);
      check("F_busy", busy, 1'b0);
      check("F_dirty_kept", dirty, 1'b1);
      bus.sd_buff_wr = 1'b1;
      tick(1);
      bus.sd_buff_wr = 1'b0;
      check("F_idle_strobe", bus.mem_req, 1'b0);
      mount(0, 32'd1024);
      serve(0, 1'b0, m_nsect[0], 1'b0);
      check("F_error_clr", error, 1'b0);
      downloading = 1'b1;
      tick(1);
      downloading = 1'b0;
      m_ena = '0;
      tick(2);

      // G: both slots mounted together -> slot 0 fully, then slot 1
      rs = req_starts;
      sz = 32'($urandom_range(1, 3)) * 32'd512 + 32'($urandom_range(0, 511));
      img_mounted = 2'b11;
      img_size = sz;
      tick(1);
      img_mounted = '0;
      m_ena = 2'b11;
      m_nsect[0] = exp_nsect(sz);
      m_nsect[1] = exp_nsect(sz);
      serve(0, 1'b0, m_nsect[0], 1'b0);
      serve(1, 1'b0, m_nsect[1], 1'b0);
      tick(4);
      check("G_sectors", req_starts - rs, 2 * m_nsect[0]);
      check("G_ena", ena, m_ena);

      // H: remount of the active slot mid-transfer
      rs = req_starts;
      mount(0, 32'd1536);
      fork
         serve(0, 1'b0, 3, 1'b0);
         begin
            tick(12);
            mount(0, 32'd1024);
         end
      join
      serve(0, 1'b0, m_nsect[0], 1'b0);
      tick(4);
      check("H_sectors", req_starts - rs, 5);

      // random mounts
      for (int it = 0; it < 4; it++) begin
         slot = $urandom_range(0, 1);
         if (it == 0) sz = 32'($urandom_range(1, 511));
         else         sz = 32'($urandom_range(1, 6)) * 32'd512 + 32'($urandom_range(0, 511));
         rs = req_starts;
         mount(slot, sz);
         n = m_nsect[slot];
         serve(slot, 1'b0, n, 1'b0);
         tick(4);
         check("R_sectors", req_starts - rs, n);
         check("R_ena", ena, m_ena);
      end

      // reset mid-transfer
      mount(1, 32'd2048);
      w = 0;
      while (bus.sd_rd == '0 && w < 50) begin
         tick(1);
         w++;
      end
      reset_n = 1'b0;
      #1;
      check("X_rst_rd", bus.sd_rd, '0);
      check("X_rst_status", {ena, busy, dirty, error}, '0);
      tick(2);
      reset_n = 1'b1;
      rs = req_starts;
      tick(20);
      check("X_no_resume", req_starts - rs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
